seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

Time-multiplexed driver for the 4-digit common-anode seven-segment display, sitting directly downstream of the time/alarm display mux. Takes the selected BCD display time and PM flag, snapshots them once per frame, and scans one digit at a time. Drives active-low anodes, segments and decimal point. Adds leading-zero blanking, invalid-BCD indication, a PM dot and whole-display blinking for set modes.

## Interface
- DECIMAL_DIGITS, 4, number of BCD digits scanned; digit 0 is the least significant (minute ones).
- REFRESH_DIV, 100000, clock cycles each digit stays lit; must be ≥ 2.
- BLINK_DIV, 50000000, clock cycles per blink half-period; must be ≥ 2.

- i_Clk  input  1  system clock; all state on its rising edge.
- i_Rst_N  input  1  asynchronous, active-low reset.
- i_Display_Time  input  4*DECIMAL_DIGITS  BCD time; digit k at [4k+3:4k].
- i_Display_PM  input  1  PM flag for the displayed time.
- i_Blink_En  input  1  1 = blink entire display.
- o_Anode  output  DECIMAL_DIGITS  active-low one-hot digit enable; bit k = digit k.
- o_Segment  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- o_DP  output  1  active-low decimal point.

## Operation
- Refresh counter counts 0..REFRESH_DIV-1, wraps. On terminal count, digit index advances 0→1→…→DECIMAL_DIGITS-1→0.
- Shadow register (time + PM) loads from inputs on the terminal-count cycle where index = DECIMAL_DIGITS-1, i.e. at each frame boundary. Shadow is the only data source for outputs, so a frame is always coherent. Shadow resets to 0.
- Decode of the selected shadow digit: 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19, 5→0x12, 6→0x02, 7→0x78, 8→0x00, 9→0x10. Values 0xA-0xF→0x3F (dash).
- Leading-zero blank: if the most significant digit (index DECIMAL_DIGITS-1) is 0, o_Segment = 0x7F for that digit. Its anode is still asserted. No other digit is blanked.
- PM dot: o_DP = 0 only while digit 0 is selected and shadow PM = 1; otherwise 1.
- Blink counter free-runs 0..BLINK_DIV-1. On terminal count it toggles a phase bit. The phase bit resets to "on".
  - While i_Blink_En = 1 and phase = off: o_Anode = all ones, o_Segment = 0x7F, o_DP = 1.
  - Refresh counter, index and shadow keep running during the off phase.
- i_Blink_En is not synchronised inside this block; it comes from the i_Clk domain.

## Timing
- All outputs are registered.
  - o_Anode, o_Segment and o_DP reflect the index/shadow/phase state of the previous cycle: 1-cycle latency from an index change to an output change.
  - Anode and segments always change on the same edge, so there is no ghosting cycle.
- Reset (i_Rst_N = 0, any time including mid-frame) forces asynchronously: o_Anode = all ones, o_Segment = 0x7F, o_DP = 1, counters = 0, index = 0, shadow = 0, phase = on.
- First rising edge after reset release: o_Anode = ~1 (digit 0), showing shadow = 0. Digit 0 shows 0x40; the MS digit is blanked.
- Input-to-display latency: new input is visible from the first digit-0 slot after the next frame boundary. Worst case ≈ DECIMAL_DIGITS*REFRESH_DIV + 1 cycles.
- Blink on/off: takes effect on the cycle after the phase toggle, or after the i_Blink_En change.
- If a blink terminal count and a refresh terminal count fall on the same cycle, both act independently in that cycle.

## Test plan
Bench parameters: DECIMAL_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=64.
- Reset:
  - Hold i_Rst_N low → o_Anode=4'hF, o_Segment=0x7F, o_DP=1.
  - Pulse i_Rst_N low mid-digit → outputs return to those values without waiting for a clock edge.
  - After release, first frame shows digit0=0x40 and digit3 blank.
- Scan: i_Display_Time=16'h1159, i_Display_PM=1, held through one frame boundary →
  - o_Anode cycles E,D,B,7, 4 cycles each.
  - o_Segment 0x10,0x12,0x79,0x79 respectively.
  - o_DP=0 only while o_Anode=E.
- Leading zero: 16'h0905 →
  - digit3 slot: o_Anode=7, o_Segment=0x7F.
  - digit1: 0x40. digit2: 0x10. digit0: 0x12.
- Frame coherence: switch input 16'h1159→16'h1200 during the digit-1 slot → digits 2,3 of this frame still show 1,1 (0x79). The next frame shows 0x40,0x40,0x24,0x79.
- Invalid BCD: 16'h1A59 → digit2 o_Segment=0x3F; other digits decode normally.
- Blink: i_Blink_En=1 →
  - alternating 64-cycle windows of o_Anode=F/o_Segment=0x7F and normal scanning.
  - Deassert i_Blink_En in an off window → scanning resumes the next cycle at the current index.

Source files
------------

// File: rtl/seven_segment_scanner_if.sv
// rtl/seven_segment_scanner_if.sv - display data in / multiplexed display drive out
interface seven_segment_scanner_if #(
    parameter int DECIMAL_DIGITS = 4
);
    logic [4*DECIMAL_DIGITS-1:0] i_Display_Time;
    logic                        i_Display_PM;
    logic                        i_Blink_En;
    logic [DECIMAL_DIGITS-1:0]   o_Anode;
    logic [6:0]                  o_Segment;
    logic                        o_DP;

    modport master (
        output i_Display_Time, i_Display_PM, i_Blink_En,
        input  o_Anode, o_Segment, o_DP
    );

    modport slave (
        input  i_Display_Time, i_Display_PM, i_Blink_En,
        output o_Anode, o_Segment, o_DP
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - multiplexed seven-segment driver with frame snapshot, blanking, PM dot and blink
module seven_segment_scanner #(
    parameter int DECIMAL_DIGITS = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLINK_DIV      = 50000000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_N,
    seven_segment_scanner_if.slave disp
);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV);
    localparam int IDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DECIMAL_DIGITS - 1);

    logic [REF_W-1:0]            r_refresh_cnt;
    logic [BLK_W-1:0]            r_blink_cnt;
    logic [IDX_W-1:0]            r_digit_idx;
    logic [4*DECIMAL_DIGITS-1:0] r_shadow_time;
    logic                        r_shadow_pm;
    logic                        r_blink_on;
    logic [DECIMAL_DIGITS-1:0]   r_anode;
    logic [6:0]                  r_segment;
    logic                        r_dp;

    logic                        w_refresh_tc;
    logic                        w_blink_tc;
    logic                        w_frame_end;
    logic [3:0]                  w_digit;
    logic [6:0]                  w_decoded;
    logic                        w_dark;
    logic [DECIMAL_DIGITS-1:0]   w_anode_nxt;
    logic [6:0]                  w_segment_nxt;
    logic                        w_dp_nxt;

    assign w_refresh_tc = (r_refresh_cnt == REF_LAST);
    assign w_blink_tc   = (r_blink_cnt == BLK_LAST);
    assign w_frame_end  = w_refresh_tc && (r_digit_idx == IDX_LAST);
    assign w_dark       = disp.i_Blink_En && !r_blink_on;

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= '0;
        end else if (w_refresh_tc) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + IDX_W'(1);
        end else begin
            r_refresh_cnt <= r_refresh_cnt + REF_W'(1);
        end
    end

    // Snapshot only at the frame boundary so all digits of one frame come from one sample.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_shadow_time <= '0;
            r_shadow_pm   <= 1'b0;
        end else if (w_frame_end) begin
            r_shadow_time <= disp.i_Display_Time;
            r_shadow_pm   <= disp.i_Display_PM;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_blink_tc) begin
            r_blink_cnt <= '0;
            r_blink_on  <= !r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLK_W'(1);
        end
    end

    always_comb begin
        w_digit = '0;
        for (int k = 0; k < DECIMAL_DIGITS; k++) begin
            if (r_digit_idx == IDX_W'(k)) w_digit = r_shadow_time[4*k +: 4];
        end
    end

    always_comb begin
        case (w_digit)
            4'd0:    w_decoded = 7'h40;
            4'd1:    w_decoded = 7'h79;
            4'd2:    w_decoded = 7'h24;
            4'd3:    w_decoded = 7'h30;
            4'd4:    w_decoded = 7'h19;
            4'd5:    w_decoded = 7'h12;
            4'd6:    w_decoded = 7'h02;
            4'd7:    w_decoded = 7'h78;
            4'd8:    w_decoded = 7'h00;
            4'd9:    w_decoded = 7'h10;
            default: w_decoded = 7'h3F;
        endcase
    end

    always_comb begin
        w_anode_nxt   = ~(DECIMAL_DIGITS'(1) << r_digit_idx);
        w_segment_nxt = w_decoded;
        w_dp_nxt      = !((r_digit_idx == '0) && r_shadow_pm);
        if ((r_digit_idx == IDX_LAST) && (w_digit == 4'd0)) w_segment_nxt = 7'h7F;
        if (w_dark) begin
            w_anode_nxt   = '1;
            w_segment_nxt = 7'h7F;
            w_dp_nxt      = 1'b1;
        end
    end

    // Anode and segments share one register stage so they always switch together.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_anode   <= '1;
            r_segment <= 7'h7F;
            r_dp      <= 1'b1;
        end else begin
            r_anode   <= w_anode_nxt;
            r_segment <= w_segment_nxt;
            r_dp      <= w_dp_nxt;
        end
    end

    assign disp.o_Anode   = r_anode;
    assign disp.o_Segment = r_segment;
    assign disp.o_DP      = r_dp;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - scoreboard bench for seven_segment_scanner
module tb_seven_segment_scanner;
    localparam int N  = 4;
    localparam int RD = 4;
    localparam int BD = 64;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] sb_q[$];
    int unsigned m_t;
    logic [15:0] m_shadow;
    logic        m_pm;

    seven_segment_scanner_if #(.DECIMAL_DIGITS(N)) u_if ();

    seven_segment_scanner #(
        .DECIMAL_DIGITS(N),
        .REFRESH_DIV   (RD),
        .BLINK_DIV     (BD)
    ) u_dut (
        .i_Clk  (clk),
        .i_Rst_N(rst_n),
        .disp   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Reference: position in time since reset decides digit, blink phase and frame boundaries.
    initial begin
        m_t = 0; m_shadow = '0; m_pm = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_t = 0; m_shadow = '0; m_pm = 1'b0;
                sb_q.push_back({4'hF, 7'h7F, 1'b1});
            end else begin
                int          idx;
                logic [15:0] sh;
                logic [3:0]  dig;
                logic [3:0]  an;
                logic [6:0]  sg;
                logic        dp;
                idx = int'((m_t / RD) % N);
                sh  = m_shadow >> (4 * idx);
                dig = sh[3:0];
                an  = ~(4'b0001 << idx);
                sg  = (idx == N - 1 && dig == 4'd0) ? 7'h7F : seg_of(dig);
                dp  = !(idx == 0 && m_pm);
                if (u_if.i_Blink_En && ((m_t / BD) % 2 == 1)) begin
                    an = 4'hF; sg = 7'h7F; dp = 1'b1;
                end
                sb_q.push_back({an, sg, dp});
                if (m_t % (RD * N) == RD * N - 1) begin
                    m_shadow = u_if.i_Display_Time;
                    m_pm     = u_if.i_Display_PM;
                end
                m_t++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                logic [11:0] e;
                e = sb_q.pop_front();
                check_eq("scoreboard", {u_if.o_Anode, u_if.o_Segment, u_if.o_DP}, e);
            end
        end
    end

    task automatic wait_slot0();
        logic [3:0] prev;
        bit found;
        prev  = u_if.o_Anode;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (u_if.o_Anode == 4'hE && prev == 4'h7) found = 1'b1;
            prev = u_if.o_Anode;
        end
        check_eq("sync_slot0", {31'd0, found}, 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [27:0] segs, input logic pm,
                               input bit do_switch, input logic [15:0] new_time);
        for (int s = 0; s < N; s++) begin
            for (int c = 0; c < RD; c++) begin
                logic [3:0] ea;
                logic [6:0] es;
                logic       ed;
                if (s != 0 || c != 0) @(negedge clk);
                ea = ~(4'b0001 << s);
                es = segs[7*s +: 7];
                ed = (s == 0 && pm) ? 1'b0 : 1'b1;
                check_eq({tag, "_anode"}, {28'd0, u_if.o_Anode}, {28'd0, ea});
                check_eq({tag, "_seg"}, {25'd0, u_if.o_Segment}, {25'd0, es});
                check_eq({tag, "_dp"}, {31'd0, u_if.o_DP}, {31'd0, ed});
                if (do_switch && s == 1 && c == 0) begin
                    #1;
                    u_if.i_Display_Time = new_time;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        u_if.i_Display_Time = 16'h0000;
        u_if.i_Display_PM   = 1'b0;
        u_if.i_Blink_En     = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check_eq("reset_anode", {28'd0, u_if.o_Anode}, 32'hF);
            check_eq("reset_seg", {25'd0, u_if.o_Segment}, 32'h7F);
            check_eq("reset_dp", {31'd0, u_if.o_DP}, 32'd1);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("first_anode", {28'd0, u_if.o_Anode}, 32'hE);
        check_eq("first_seg", {25'd0, u_if.o_Segment}, 32'h40);
        repeat (12) @(negedge clk);
        check_eq("first_msd_anode", {28'd0, u_if.o_Anode}, 32'h7);
        check_eq("first_msd_blank", {25'd0, u_if.o_Segment}, 32'h7F);

        #1;
        u_if.i_Display_Time = 16'h1159;
        u_if.i_Display_PM   = 1'b1;
        repeat (17) @(negedge clk);
        wait_slot0();
        check_frame("scan", {7'h79, 7'h79, 7'h12, 7'h10}, 1'b1, 1'b0, 16'h0);

        #1;
        u_if.i_Display_Time = 16'h0905;
        u_if.i_Display_PM   = 1'b0;
        repeat (17) @(negedge clk);
        wait_slot0();
        check_frame("lead0", {7'h7F, 7'h10, 7'h40, 7'h12}, 1'b0, 1'b0, 16'h0);

        @(negedge clk);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_anode", {28'd0, u_if.o_Anode}, 32'hF);
        check_eq("async_seg", {25'd0, u_if.o_Segment}, 32'h7F);
        check_eq("async_dp", {31'd0, u_if.o_DP}, 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;

        u_if.i_Display_Time = 16'h1159;
        u_if.i_Display_PM   = 1'b1;
        repeat (17) @(negedge clk);
        wait_slot0();
        check_frame("coh_old", {7'h79, 7'h79, 7'h12, 7'h10}, 1'b1, 1'b1, 16'h1200);
        @(negedge clk);
        check_frame("coh_new", {7'h79, 7'h24, 7'h40, 7'h40}, 1'b1, 1'b0, 16'h0);

        #1 u_if.i_Display_Time = 16'h1A59;
        repeat (17) @(negedge clk);
        wait_slot0();
        check_frame("badbcd", {7'h79, 7'h3F, 7'h12, 7'h10}, 1'b1, 1'b0, 16'h0);

        #1 u_if.i_Blink_En = 1'b1;
        begin
            bit dark;
            dark = 1'b0;
            for (int i = 0; i < 140 && !dark; i++) begin
                @(negedge clk);
                if (u_if.o_Anode == 4'hF) dark = 1'b1;
            end
            check_eq("blink_dark_seen", {31'd0, dark}, 32'd1);
        end
        repeat (5) @(negedge clk);
        check_eq("blink_off_anode", {28'd0, u_if.o_Anode}, 32'hF);
        #1 u_if.i_Blink_En = 1'b0;
        @(negedge clk);
        check_eq("blink_resume", {31'd0, (u_if.o_Anode != 4'hF)}, 32'd1);
        #1 u_if.i_Blink_En = 1'b1;
        repeat (200) @(negedge clk);
        #1 u_if.i_Blink_En = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
